// File: rtl/block_write_data.sv
// block_write_data: write-back of one datapath register into data RAM.
// A rising edge of i_wr_en captures the selected source register and the
// target address, then a write request is held on the RAM port until the
// RAM acknowledges or the cycle budget runs out. The result is reported as
// a one-cycle o_done (acknowledged) or o_err (invalid select / timeout).
module block_write_data #(
    parameter int SIZE_DATA = 8,
    parameter int SIZE_ADDR = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_en,
    input  logic [1:0]           i_sel_data_wr,
    input  logic [SIZE_DATA-1:0] i_temp_min,
    input  logic [SIZE_DATA-1:0] i_temp_data,
    input  logic [SIZE_DATA-1:0] i_data_key,
    input  logic [SIZE_ADDR-1:0] i_addr,
    input  logic                 i_ram_ack,
    output logic                 o_wr_en,
    output logic [SIZE_ADDR-1:0] o_addr,
    output logic [SIZE_DATA-1:0] o_data_ram,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    // Counter only has to reach TIMEOUT-1, so it never wraps.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    // Source selection: 11 temp_min, 10 temp_data, 01 data_key.
    // 00 is rejected before this is used; it returns zero for completeness.
    function automatic logic [SIZE_DATA-1:0] sel_source(
        input logic [1:0]           sel,
        input logic [SIZE_DATA-1:0] temp_min,
        input logic [SIZE_DATA-1:0] temp_data,
        input logic [SIZE_DATA-1:0] data_key
    );
        logic [SIZE_DATA-1:0] res;
        case (sel)
            2'b11:   res = temp_min;
            2'b10:   res = temp_data;
            2'b01:   res = data_key;
            default: res = {SIZE_DATA{1'b0}};
        endcase
        return res;
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic                 capture_s;
    logic                 start_s;
    logic                 r_wr_prev;
    logic                 wr_en_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;
    logic [SIZE_ADDR-1:0] addr_r;
    logic [SIZE_DATA-1:0] data_r;

    // Only a low-to-high transition of the command level starts a write.
    assign start_s = i_wr_en & ~r_wr_prev;

    // Next-state, counter and capture decision.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (i_sel_data_wr == 2'b00) begin
                        state_nxt_s = ST_ERR;
                    end else begin
                        state_nxt_s = ST_REQ;
                        capture_s   = 1'b1;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // An ack on the timeout edge still counts as success.
                if (i_ram_ack) begin
                    state_nxt_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            ST_ERR:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and timeout counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Edge-detect history; tracks i_wr_en in every state so a held level never retriggers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_prev <= 1'b0;
        end else begin
            r_wr_prev <= i_wr_en;
        end
    end

    // Address/data capture; values persist until the next valid capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_r <= {SIZE_ADDR{1'b0}};
            data_r <= {SIZE_DATA{1'b0}};
        end else if (capture_s) begin
            addr_r <= i_addr;
            data_r <= sel_source(i_sel_data_wr, i_temp_min, i_temp_data, i_data_key);
        end
    end

    // Status outputs registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_en_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            wr_en_r <= (state_nxt_s == ST_REQ);
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
            err_r   <= (state_nxt_s == ST_ERR);
        end
    end

    assign o_wr_en    = wr_en_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_err      = err_r;
    assign o_addr     = addr_r;
    assign o_data_ram = data_r;

endmodule

// File: tb/tb_block_write_data.sv
// Self-checking bench for block_write_data (default parameters).
// Expected transaction results are queued when a start is driven and
// popped when the DUT reports o_done / o_err.
module tb_block_write_data;

    logic       i_clk;
    logic       i_rst;
    logic       i_wr_en;
    logic [1:0] i_sel_data_wr;
    logic [7:0] i_temp_min;
    logic [7:0] i_temp_data;
    logic [7:0] i_data_key;
    logic [7:0] i_addr;
    logic       i_ram_ack;
    logic       o_wr_en;
    logic [7:0] o_addr;
    logic [7:0] o_data_ram;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    block_write_data #(
        .SIZE_DATA(8),
        .SIZE_ADDR(8),
        .TIMEOUT  (16)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr_en      (i_wr_en),
        .i_sel_data_wr(i_sel_data_wr),
        .i_temp_min   (i_temp_min),
        .i_temp_data  (i_temp_data),
        .i_data_key   (i_data_key),
        .i_addr       (i_addr),
        .i_ram_ack    (i_ram_ack),
        .o_wr_en      (o_wr_en),
        .o_addr       (o_addr),
        .o_data_ram   (o_data_ram),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    typedef struct {
        logic       is_err;
        int         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp;
    int         n_bad;
    logic [7:0] m_addr;
    logic [7:0] m_data;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference source mapping.
    function automatic logic [7:0] ref_src(input logic [1:0] sel, input logic [7:0] tmin,
                                           input logic [7:0] tdat, input logic [7:0] key,
                                           input logic [7:0] old);
        if (sel == 2'b11) return tmin;
        if (sel == 2'b10) return tdat;
        if (sel == 2'b01) return key;
        return old;
    endfunction

    // Drive a start request at the current negedge and queue its expectation.
    task automatic drive_start(input logic [1:0] sel, input logic [7:0] tmin, input logic [7:0] tdat,
                               input logic [7:0] key, input logic [7:0] addr, input int wr_cycles,
                               input logic is_err);
        exp_t e;
        i_sel_data_wr = sel;
        i_temp_min    = tmin;
        i_temp_data   = tdat;
        i_data_key    = key;
        i_addr        = addr;
        i_wr_en       = 1'b1;
        if (sel != 2'b00) m_addr = addr;
        m_data   = ref_src(sel, tmin, tdat, key, m_data);
        e.is_err = is_err;
        e.wr     = wr_cycles;
        e.addr   = m_addr;
        e.data   = m_data;
        sb.push_back(e);
    endtask

    // Observe one transaction until its result pulse has passed and the block is idle.
    task automatic observe(input int ack_at, input int rep_at, input int budget,
                           output int wr_cnt, output int done_cnt, output int err_cnt,
                           output int res_iter, output logic stable, output logic timed_out);
        logic [7:0] a0;
        logic [7:0] d0;
        logic       seen;
        wr_cnt = 0; done_cnt = 0; err_cnt = 0; res_iter = 0;
        stable = 1'b1; timed_out = 1'b1; seen = 1'b0;
        a0 = 8'h00; d0 = 8'h00;
        for (int it = 1; it <= budget; it++) begin
            @(negedge i_clk);
            if (o_wr_en === 1'b1) begin
                wr_cnt++;
                if (wr_cnt == 1) begin
                    a0 = o_addr;
                    d0 = o_data_ram;
                end else if (o_addr !== a0 || o_data_ram !== d0) begin
                    stable = 1'b0;
                end
            end
            if (o_done === 1'b1) done_cnt++;
            if (o_err === 1'b1) err_cnt++;
            if (!seen && (o_done === 1'b1 || o_err === 1'b1)) begin
                seen = 1'b1;
                res_iter = it;
            end
            i_ram_ack = (o_wr_en === 1'b1) && (ack_at > 0) && (wr_cnt == ack_at);
            i_wr_en   = (o_wr_en === 1'b1) && (rep_at > 0) && (wr_cnt == rep_at);
            if (seen && o_busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
        i_ram_ack = 1'b0;
        i_wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        int wr, dn, er, ri;
        logic st, to;
        exp_t e;
        i_rst = 1'b1;
        i_wr_en = 1'($urandom_range(0, 1));
        i_sel_data_wr = 2'($urandom_range(0, 3));
        i_temp_min = 8'($urandom); i_temp_data = 8'($urandom);
        i_data_key = 8'($urandom); i_addr = 8'($urandom);
        i_ram_ack = 1'($urandom_range(0, 1));
        @(negedge i_clk);
        i_wr_en = 1'b1;
        i_ram_ack = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (o_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %b want 0", o_wr_en); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
        n_cmp++; if (o_done !== 1'b0 || o_err !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got done=%b err=%b want 0/0", o_done, o_err); end
        n_cmp++; if (o_addr !== 8'h00 || o_data_ram !== 8'h00) begin n_bad++; $display("FAIL reset_addr_data got %h/%h want 00/00", o_addr, o_data_ram); end
        m_addr = 8'h00; m_data = 8'h00;
        // Release reset with i_wr_en still high: first edge after reset is a start.
        i_rst = 1'b0;
        drive_start(2'b01, 8'h11, 8'h22, 8'hC3, 8'h44, 1, 1'b0);
        observe(1, 0, 40, wr, dn, er, ri, st, to);
        e = sb.pop_front();
        n_cmp++; if (to) begin n_bad++; $display("FAIL rst_release_timeout got no result want result"); end
        n_cmp++; if (dn !== 1 || er !== 0) begin n_bad++; $display("FAIL rst_release_result got done=%0d err=%0d want 1/0", dn, er); end
        n_cmp++; if (wr !== e.wr || ri !== e.wr + 1) begin n_bad++; $display("FAIL rst_release_timing got wr=%0d res=%0d want %0d/%0d", wr, ri, e.wr, e.wr + 1); end
        n_cmp++; if (o_addr !== e.addr || o_data_ram !== e.data) begin n_bad++; $display("FAIL rst_release_data got %h/%h want %h/%h", o_addr, o_data_ram, e.addr, e.data); end
    endtask

    task automatic test_valid_write();
        int wr, dn, er, ri;
        logic st, to;
        exp_t e;
        drive_start(2'b10, 8'h0F, 8'h5A, 8'hF0, 8'h21, 3, 1'b0);
        observe(3, 0, 40, wr, dn, er, ri, st, to);
        e = sb.pop_front();
        n_cmp++; if (to) begin n_bad++; $display("FAIL valid_timeout got no result want result"); end
        n_cmp++; if (dn !== 1 || er !== 0) begin n_bad++; $display("FAIL valid_result got done=%0d err=%0d want 1/0", dn, er); end
        n_cmp++; if (wr !== e.wr || ri !== e.wr + 1) begin n_bad++; $display("FAIL valid_timing got wr=%0d res=%0d want %0d/%0d", wr, ri, e.wr, e.wr + 1); end
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL valid_stable got %b want 1", st); end
        n_cmp++; if (o_addr !== e.addr || o_data_ram !== e.data) begin n_bad++; $display("FAIL valid_data got %h/%h want %h/%h", o_addr, o_data_ram, e.addr, e.data); end
    endtask

    task automatic test_select_map();
        int wr, dn, er, ri;
        logic st, to;
        exp_t e;
        logic [1:0] sels[2];
        sels[0] = 2'b11;
        sels[1] = 2'b01;
        for (int k = 0; k < 2; k++) begin
            drive_start(sels[k], 8'hA1, 8'h77, 8'h3C, 8'(8'h60 + k), 2, 1'b0);
            observe(2, 0, 40, wr, dn, er, ri, st, to);
            e = sb.pop_front();
            n_cmp++; if (to || dn !== 1 || er !== 0) begin n_bad++; $display("FAIL selmap_result sel=%b got done=%0d err=%0d to=%b want 1/0/0", sels[k], dn, er, to); end
            n_cmp++; if (wr !== e.wr) begin n_bad++; $display("FAIL selmap_wr sel=%b got %0d want %0d", sels[k], wr, e.wr); end
            n_cmp++; if (o_addr !== e.addr || o_data_ram !== e.data) begin n_bad++; $display("FAIL selmap_data sel=%b got %h/%h want %h/%h", sels[k], o_addr, o_data_ram, e.addr, e.data); end
        end
    endtask

    task automatic test_invalid_sel();
        int wr, dn, er, ri;
        logic st, to;
        exp_t e;
        drive_start(2'b00, 8'h99, 8'h88, 8'h77, 8'hEE, 0, 1'b1);
        observe(0, 0, 40, wr, dn, er, ri, st, to);
        e = sb.pop_front();
        n_cmp++; if (to || er !== 1 || dn !== 0) begin n_bad++; $display("FAIL invalid_result got done=%0d err=%0d to=%b want 0/1/0", dn, er, to); end
        n_cmp++; if (ri !== 1) begin n_bad++; $display("FAIL invalid_err_timing got iter %0d want 1", ri); end
        n_cmp++; if (wr !== 0) begin n_bad++; $display("FAIL invalid_wr_en got %0d cycles want 0", wr); end
        n_cmp++; if (o_addr !== e.addr || o_data_ram !== e.data) begin n_bad++; $display("FAIL invalid_hold got %h/%h want %h/%h", o_addr, o_data_ram, e.addr, e.data); end
    endtask

    task automatic test_timeout();
        int wr, dn, er, ri;
        logic st, to;
        exp_t e;
        int acks[2];
        acks[0] = 0;
        acks[1] = 16;
        for (int k = 0; k < 2; k++) begin
            drive_start(2'b10, 8'h01, 8'(8'hB0 + k), 8'h02, 8'(8'h70 + k), 16, (acks[k] == 0));
            observe(acks[k], 0, 60, wr, dn, er, ri, st, to);
            e = sb.pop_front();
            n_cmp++; if (to) begin n_bad++; $display("FAIL timeout_run%0d got no result want result", k); end
            n_cmp++; if (er !== (e.is_err ? 1 : 0) || dn !== (e.is_err ? 0 : 1)) begin n_bad++; $display("FAIL timeout_result_run%0d got done=%0d err=%0d want err=%b", k, dn, er, e.is_err); end
            n_cmp++; if (wr !== 16 || ri !== 17) begin n_bad++; $display("FAIL timeout_len_run%0d got wr=%0d res=%0d want 16/17", k, wr, ri); end
            n_cmp++; if (st !== 1'b1 || o_addr !== e.addr || o_data_ram !== e.data) begin n_bad++; $display("FAIL timeout_data_run%0d got %h/%h st=%b want %h/%h", k, o_addr, o_data_ram, st, e.addr, e.data); end
        end
    endtask

    task automatic test_ignored();
        int wr, dn, er, ri;
        logic st, to;
        exp_t e;
        int bad_idle;
        drive_start(2'b11, 8'hD4, 8'h00, 8'h00, 8'h35, 3, 1'b0);
        observe(3, 1, 40, wr, dn, er, ri, st, to);
        e = sb.pop_front();
        n_cmp++; if (to || dn !== 1 || er !== 0) begin n_bad++; $display("FAIL ignored_restart got done=%0d err=%0d to=%b want 1/0/0", dn, er, to); end
        n_cmp++; if (wr !== e.wr || o_data_ram !== e.data) begin n_bad++; $display("FAIL ignored_restart_data got wr=%0d data=%h want %0d/%h", wr, o_data_ram, e.wr, e.data); end
        // Ack while idle must do nothing; also confirms no queued second write.
        bad_idle = 0;
        i_ram_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            if (o_busy !== 1'b0 || o_wr_en !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) bad_idle++;
        end
        i_ram_ack = 1'b0;
        n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("FAIL idle_ack got %0d active cycles want 0", bad_idle); end
    endtask

    task automatic test_back_to_back();
        int wr, dn, er, ri;
        logic st, to;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            drive_start(2'b01, 8'h00, 8'h00, 8'(8'h90 + k), 8'(8'hC0 + k), 1, 1'b0);
            observe(1, 0, 40, wr, dn, er, ri, st, to);
            e = sb.pop_front();
            n_cmp++; if (to || dn !== 1 || er !== 0 || ri !== 2) begin n_bad++; $display("FAIL b2b_result%0d got done=%0d err=%0d res=%0d want 1/0/2", k, dn, er, ri); end
            n_cmp++; if (wr !== 1 || o_addr !== e.addr || o_data_ram !== e.data) begin n_bad++; $display("FAIL b2b_data%0d got wr=%0d %h/%h want 1 %h/%h", k, wr, o_addr, o_data_ram, e.addr, e.data); end
        end
    endtask

    task automatic test_mid_reset();
        int pulses;
        exp_t e;
        drive_start(2'b10, 8'h00, 8'h6B, 8'h00, 8'h52, 0, 1'b0);
        e = sb.pop_front();
        @(negedge i_clk);
        i_wr_en = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (o_wr_en !== 1'b1 || o_data_ram !== e.data) begin n_bad++; $display("FAIL midrst_pre got wr_en=%b data=%h want 1/%h", o_wr_en, o_data_ram, e.data); end
        i_rst = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (o_wr_en !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_drop got wr_en=%b busy=%b want 0/0", o_wr_en, o_busy); end
        n_cmp++; if (o_addr !== 8'h00 || o_data_ram !== 8'h00) begin n_bad++; $display("FAIL midrst_vals got %h/%h want 00/00", o_addr, o_data_ram); end
        i_rst = 1'b0;
        pulses = (o_done === 1'b1 || o_err === 1'b1) ? 1 : 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            if (o_done !== 1'b0 || o_err !== 1'b0 || o_busy !== 1'b0) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_pulse got %0d result/busy cycles want 0", pulses); end
    endtask

    // Hard stop in case a wait somewhere never completes.
    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_addr = 8'h00;
        m_data = 8'h00;
        i_rst = 1'b1;
        i_wr_en = 1'b0;
        i_sel_data_wr = 2'b00;
        i_temp_min = 8'h00;
        i_temp_data = 8'h00;
        i_data_key = 8'h00;
        i_addr = 8'h00;
        i_ram_ack = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_valid_write();
        test_select_map();
        test_invalid_sel();
        test_timeout();
        test_ignored();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
